game_sequencer: RTL
===================

Name: game_sequencer

Overview:
- Central game-flow controller for the asteroids datapath.
- Sequences the game through idle, play, death/respawn and game-over phases.
- Converts collision event pulses into score and lives bookkeeping.
- Schedules object spawns by arbitrating the ship, 4 bullet slots and 10 rock slots onto a single one-hot spawn bus (bit map: 0 ship, 4:1 bullets, 14:5 rocks).

Parameters:
- START_LIVES, 3: lives loaded at game start (2-bit, 1..3).
- RESPAWN_FRAMES, 120: frame ticks spent in DYING before the ship respawns.
- ROCK_SPAWN_FRAMES, 30: frame ticks between rock spawn attempts.
- FIRE_COOLDOWN, 8: frame ticks after a bullet spawn before the next fire is accepted.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_game  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame (60 Hz), synchronous to clk.
- start_btn  in  1  synchronised start button, level.
- fire_btn  in  1  synchronised fire button, level.
- hit_rock  in  1  one-cycle pulse: bullet/rock collision.
- hit_ship  in  1  one-cycle pulse: ship/rock collision.
- obj_alive  in  15  per-object active flags (same bit map as spawn).
- spawn  out  15  one-hot spawn pulse, one cycle wide.
- clear_all  out  1  one-cycle pulse that despawns every object.
- state  out  3  IDLE=0, RESPAWN=1, PLAY=2, DYING=3, GAME_OVER=4.
- score  out  16  rocks destroyed.
- lives  out  2  remaining lives.
- game_over  out  1  high while in GAME_OVER.

Behaviour:
- Reset (async):
  - state=IDLE, score=0, lives=START_LIVES.
  - spawn=0, clear_all=0, game_over=0.
  - All timers, pending flags and the rock round-robin pointer cleared.
  - Reset asserted mid-game aborts every pending spawn immediately.
- Edge detection: start_btn and fire_btn are edge-detected internally, registered once. Only a 0→1 transition counts as a press.
- IDLE or GAME_OVER, start press:
  - clear_all=1 for one cycle; score=0, lives=START_LIVES, cooldown and rock timer=0.
  - Next state RESPAWN.
- RESPAWN:
  - spawn[0]=1 for exactly one cycle (the cycle after entry), then PLAY.
  - Latency start press → spawn[0] is 2 cycles.
- PLAY, hit_ship:
  - lives decrements next cycle.
  - If lives was 1: lives=0, state→GAME_OVER, game_over=1.
  - Otherwise state→DYING and the DYING frame counter is zeroed.
- DYING: counts frame_tick; after RESPAWN_FRAMES ticks goes to RESPAWN.
- hit_ship outside PLAY: ignored.
- Score:
  - hit_rock in PLAY or DYING increments score by 1, saturating at 16'hFFFF.
  - hit_rock is ignored in other states.
  - hit_rock and hit_ship in the same cycle: both take effect.
- Fire request:
  - Set on a fire press in PLAY when cooldown==0; a press during cooldown is dropped.
  - Grant goes to the lowest-index bullet k with obj_alive[k]==0 → spawn[k]=1, cooldown=FIRE_COOLDOWN.
  - No free bullet: the request is dropped, no pulse.
  - Cooldown decrements on each frame_tick down to 0.
- Rock scheduling:
  - The rock timer counts frame_tick while in PLAY or DYING.
  - At ROCK_SPAWN_FRAMES it sets rock_pending and restarts.
  - rock_pending grants the first free rock slot searching circularly from pointer+1, where pointer is the last granted slot (indices 5..14, wrapping 14→5). The grant pulses the spawn bit and updates the pointer.
  - No free rock: rock_pending holds until a slot frees; the timer does not stack a second pending.
- Arbitration:
  - At most one spawn bit per cycle; priority ship (RESPAWN) > bullet > rock.
  - A losing rock request stays pending to the next cycle.
  - A losing bullet request stays pending while in PLAY.
- Leaving PLAY (to DYING or GAME_OVER) clears a pending bullet request.
- GAME_OVER: no spawns, timers frozen; score and lives hold.
- spawn and clear_all are never asserted in the same cycle.

Test Plan:
- Reset, then start press → clear_all on cycle+1, spawn=15'h0001 on cycle+2, state=PLAY on cycle+3, lives=3, score=0.
- PLAY, obj_alive=15'h0003 (ship and bullet 1 alive), fire press → spawn=15'h0004; a second press 3 frames later → no spawn; a press 8 frames after the grant → spawn=15'h0002 if bullet 1 is now free.
- PLAY, 30 frame_ticks with all rocks free and pointer 0 → spawn=15'h0020. Next period spawns 15'h0040. With all rocks alive, no spawn until obj_alive[9] clears, then spawn=15'h0200.
- lives=3, three hit_ship pulses, each followed by 120 frame_ticks in DYING → lives 2→1→0, respawn pulse after the first two, then state=GAME_OVER with game_over=1 and no further spawns.
- Same-cycle hit_rock+hit_ship at score=16'hFFFF → score stays 16'hFFFF, lives decrements. The same cycle as a rock grant plus a fire press → the bullet spawns first and the rock spawns on the next cycle.
- reset_game asserted mid-DYING with rock_pending set → outputs return to reset values asynchronously; no spawn pulse after release.

Source files
------------

// File: rtl/game_sequencer.sv
// Game-flow controller for the asteroids datapath: phase FSM, score/lives bookkeeping
// and a single-winner spawn scheduler (ship > bullet > round-robin rock).
`timescale 1ns/1ps
module game_sequencer #(
    parameter int START_LIVES       = 3,
    parameter int RESPAWN_FRAMES    = 120,
    parameter int ROCK_SPAWN_FRAMES = 30,
    parameter int FIRE_COOLDOWN     = 8
) (
    input  logic        clk,
    input  logic        reset_game,
    input  logic        frame_tick,
    input  logic        start_btn,
    input  logic        fire_btn,
    input  logic        hit_rock,
    input  logic        hit_ship,
    input  logic [14:0] obj_alive,
    output logic [14:0] spawn,
    output logic        clear_all,
    output logic [2:0]  state,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic        game_over
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESPAWN   = 3'd1,
        ST_PLAY      = 3'd2,
        ST_DYING     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam int DIE_W  = $clog2(RESPAWN_FRAMES + 1);
    localparam int ROCK_W = $clog2(ROCK_SPAWN_FRAMES + 1);
    localparam int COOL_W = $clog2(FIRE_COOLDOWN + 1);
    localparam logic [DIE_W-1:0]  DIE_LAST   = DIE_W'(RESPAWN_FRAMES - 1);
    localparam logic [ROCK_W-1:0] ROCK_LAST  = ROCK_W'(ROCK_SPAWN_FRAMES - 1);
    localparam logic [COOL_W-1:0] COOL_INIT  = COOL_W'(FIRE_COOLDOWN);
    localparam logic [1:0]        LIVES_INIT = 2'(START_LIVES);

    state_t              state_q, state_d;
    logic [15:0]         score_q, score_d;
    logic [1:0]          lives_q, lives_d;
    logic [14:0]         spawn_q, spawn_d;
    logic                clear_all_q, clear_all_d;
    logic                game_over_q, game_over_d;
    logic                start_prev_q, fire_prev_q;
    logic                ship_issued_q, ship_issued_d;
    logic [COOL_W-1:0]   cooldown_q, cooldown_d;
    logic [ROCK_W-1:0]   rock_timer_q, rock_timer_d;
    logic                rock_pending_q, rock_pending_d;
    logic [3:0]          rock_ptr_q, rock_ptr_d;
    logic [DIE_W-1:0]    die_cnt_q, die_cnt_d;

    logic        start_press, fire_press, active;
    logic        ship_grant, fire_req, bullet_grant, rock_grant;
    logic        bullet_found, rock_found;
    logic [3:0]  bullet_onehot, rock_sel;
    logic [9:0]  rock_onehot;
    logic [4:0]  rock_start, rock_idx;

    always_comb begin
        state_d        = state_q;
        score_d        = score_q;
        lives_d        = lives_q;
        spawn_d        = '0;
        clear_all_d    = 1'b0;
        ship_issued_d  = ship_issued_q;
        cooldown_d     = cooldown_q;
        rock_timer_d   = rock_timer_q;
        rock_pending_d = rock_pending_q;
        rock_ptr_d     = rock_ptr_q;
        die_cnt_d      = die_cnt_q;

        start_press = start_btn && !start_prev_q;
        fire_press  = fire_btn && !fire_prev_q;
        active      = (state_q == ST_PLAY) || (state_q == ST_DYING);

        bullet_found  = 1'b0;
        bullet_onehot = '0;
        for (int k = 0; k < 4; k++) begin
            if (!bullet_found && !obj_alive[k+1]) begin
                bullet_found     = 1'b1;
                bullet_onehot[k] = 1'b1;
            end
        end

        // Circular search starts just after the last granted rock; a pointer outside 5..13 restarts at slot 5.
        rock_start = (rock_ptr_q >= 4'd5 && rock_ptr_q <= 4'd13) ? 5'(rock_ptr_q - 4'd4) : 5'd0;
        rock_found = 1'b0;
        rock_sel   = '0;
        rock_idx   = '0;
        for (int i = 0; i < 10; i++) begin
            rock_idx = rock_start + 5'(i);
            if (rock_idx >= 5'd10)
                rock_idx = rock_idx - 5'd10;
            if (!rock_found && !obj_alive[5 + rock_idx[3:0]]) begin
                rock_found = 1'b1;
                rock_sel   = rock_idx[3:0];
            end
        end
        rock_onehot = 10'd1 << rock_sel;

        // Nothing outranks a bullet in PLAY, so a fire request is served or dropped in its own cycle.
        ship_grant   = (state_q == ST_RESPAWN) && !ship_issued_q;
        fire_req     = (state_q == ST_PLAY) && fire_press && (cooldown_q == '0);
        bullet_grant = fire_req && bullet_found;
        rock_grant   = rock_pending_q && rock_found && !ship_grant && !bullet_grant &&
                       (state_q inside {ST_RESPAWN, ST_PLAY, ST_DYING});

        if (ship_grant)
            spawn_d = 15'h0001;
        else if (bullet_grant)
            spawn_d = {10'd0, bullet_onehot, 1'b0};
        else if (rock_grant)
            spawn_d = {rock_onehot, 5'd0};

        if (bullet_grant)
            cooldown_d = COOL_INIT;
        else if (frame_tick && cooldown_q != '0 && state_q != ST_GAME_OVER)
            cooldown_d = cooldown_q - 1'b1;

        if (rock_grant) begin
            rock_pending_d = 1'b0;
            rock_ptr_d     = rock_sel + 4'd5;
        end
        if (active && frame_tick) begin
            if (rock_timer_q == ROCK_LAST) begin
                rock_timer_d   = '0;
                rock_pending_d = 1'b1;
            end else begin
                rock_timer_d = rock_timer_q + 1'b1;
            end
        end

        if (active && hit_rock && score_q != 16'hFFFF)
            score_d = score_q + 16'd1;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_press) begin
                    state_d        = ST_RESPAWN;
                    clear_all_d    = 1'b1;
                    score_d        = '0;
                    lives_d        = LIVES_INIT;
                    cooldown_d     = '0;
                    rock_timer_d   = '0;
                    rock_pending_d = 1'b0;
                    ship_issued_d  = 1'b0;
                end
            end
            ST_RESPAWN: begin
                if (ship_issued_q) begin
                    state_d       = ST_PLAY;
                    ship_issued_d = 1'b0;
                end else begin
                    ship_issued_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (hit_ship) begin
                    lives_d   = lives_q - 2'd1;
                    die_cnt_d = '0;
                    state_d   = (lives_q == 2'd1) ? ST_GAME_OVER : ST_DYING;
                end
            end
            ST_DYING: begin
                if (frame_tick) begin
                    if (die_cnt_q == DIE_LAST) begin
                        state_d       = ST_RESPAWN;
                        ship_issued_d = 1'b0;
                    end else begin
                        die_cnt_d = die_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        game_over_d = (state_d == ST_GAME_OVER);
    end

    always_ff @(posedge clk or posedge reset_game) begin
        if (reset_game) begin
            state_q        <= ST_IDLE;
            score_q        <= '0;
            lives_q        <= LIVES_INIT;
            spawn_q        <= '0;
            clear_all_q    <= 1'b0;
            game_over_q    <= 1'b0;
            start_prev_q   <= 1'b0;
            fire_prev_q    <= 1'b0;
            ship_issued_q  <= 1'b0;
            cooldown_q     <= '0;
            rock_timer_q   <= '0;
            rock_pending_q <= 1'b0;
            rock_ptr_q     <= '0;
            die_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            score_q        <= score_d;
            lives_q        <= lives_d;
            spawn_q        <= spawn_d;
            clear_all_q    <= clear_all_d;
            game_over_q    <= game_over_d;
            start_prev_q   <= start_btn;
            fire_prev_q    <= fire_btn;
            ship_issued_q  <= ship_issued_d;
            cooldown_q     <= cooldown_d;
            rock_timer_q   <= rock_timer_d;
            rock_pending_q <= rock_pending_d;
            rock_ptr_q     <= rock_ptr_d;
            die_cnt_q      <= die_cnt_d;
        end
    end

    assign spawn     = spawn_q;
    assign clear_all = clear_all_q;
    assign state     = state_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign game_over = game_over_q;
endmodule
